// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-entry busy scoreboard and a one-entry-per-clock clear sweep after reset.
// Optional write-through forwarding on the read ports when RF_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_done,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);
  localparam int DEPTH = 1 << AW;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic            run, wr_ok;
  logic [1:0][AW-1:0]   ra;
  logic [1:0][XLEN-1:0] rdat;
  logic [1:0]           rbsy;

  assign run       = (state == S_RUN);
  assign init_done = run;
  assign wr_ok     = we && !(ZERO_REG != 0 && wa == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else if (!run) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH-1)) state <= S_RUN;
    end
  end

  // No reset on the array so it can map onto RAM; the sweep owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (!run)       mem[cnt] <= '0;
    else if (wr_ok) mem[wa]  <= wd;
  end

  // Set is applied after clear so a same-entry alloc keeps the new instruction pending.
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      if (we)       busy_nxt[wa]         = 1'b0;
      if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign ra = {rs2_addr, rs1_addr};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = '0;
      rbsy[p] = 1'b0;
      if (run && !(ZERO_REG != 0 && ra[p] == '0)) begin
`ifdef RF_BYPASS_EN
        if (we && ra[p] == wa) begin
          rdat[p] = wd;
          rbsy[p] = alloc_en && (alloc_addr == wa);
        end else
`endif
        begin
          rdat[p] = mem[ra[p]];
          rbsy[p] = busy[ra[p]];
        end
      end
    end
  end

  assign rs1_data = rdat[0];
  assign rs2_data = rdat[1];
  assign rs1_busy = rbsy[0];
  assign rs2_busy = rbsy[1];
endmodule
